// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for the whole cyc burst, 1-cycle grant latency.
// Optional slave-response watchdog when WB_ARB_TIMEOUT_EN is defined (limit TIMEOUT_CYC).
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic [1:0]  m0_wb_tid_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic [1:0]  m1_wb_tid_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic [31:0] s_wb_dat_o,
  output logic [31:0] s_wb_adr_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic [1:0]  s_wb_tid_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_q, last_d;
  logic   busy;
  logic   req0, req1;
  logic   g_cyc;
  logic   to_pulse;

  assign busy  = (state_q == BUSY);
  assign req0  = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1  = m1_wb_cyc_i & m1_wb_stb_i;
  assign g_cyc = gnt_q ? m1_wb_cyc_i : m0_wb_cyc_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Under contention the master that did not win last time goes next.
          state_d = BUSY;
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          last_d  = (req0 && req1) ? ~last_q : req1;
        end
      end
      BUSY: begin
        if (!g_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_wb_dat_o  = '0;
    s_wb_adr_o  = '0;
    s_wb_sel_o  = '0;
    s_wb_we_o   = 1'b0;
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_tid_o  = '0;
    m0_wb_dat_o = '0;
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m1_wb_dat_o = '0;
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;
    if (busy) begin
      if (gnt_q) begin
        s_wb_dat_o  = m1_wb_dat_i;
        s_wb_adr_o  = m1_wb_adr_i;
        s_wb_sel_o  = m1_wb_sel_i;
        s_wb_we_o   = m1_wb_we_i;
        s_wb_cyc_o  = m1_wb_cyc_i;
        s_wb_stb_o  = m1_wb_stb_i;
        s_wb_tid_o  = m1_wb_tid_i;
        m1_wb_dat_o = s_wb_dat_i;
        m1_wb_ack_o = s_wb_ack_i;
        m1_wb_err_o = s_wb_err_i | to_pulse;
      end else begin
        s_wb_dat_o  = m0_wb_dat_i;
        s_wb_adr_o  = m0_wb_adr_i;
        s_wb_sel_o  = m0_wb_sel_i;
        s_wb_we_o   = m0_wb_we_i;
        s_wb_cyc_o  = m0_wb_cyc_i;
        s_wb_stb_o  = m0_wb_stb_i;
        s_wb_tid_o  = m0_wb_tid_i;
        m0_wb_dat_o = s_wb_dat_i;
        m0_wb_ack_o = s_wb_ack_i;
        m0_wb_err_o = s_wb_err_i | to_pulse;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  logic [15:0] cnt_q, cnt_d;

  // An ack in the limit cycle beats the watchdog.
  assign to_pulse = busy && s_wb_stb_o && !s_wb_ack_i && (cnt_q == TO_LIM);

  always_comb begin
    cnt_d = '0;
    if (busy && s_wb_stb_o && !s_wb_ack_i && !s_wb_err_i && !to_pulse)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign to_pulse   = 1'b0;
`endif

endmodule
